async_fifo_wr_arb: RTL
======================

ASYNC_FIFO_WR_ARB -- requirements
Module: async_fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DAT_BIT, default 32, data width per requester and toward the FIFO.
REQ-003 Parameter BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 The block SHALL use one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-005 clk  input  1  write-domain clock of the shared FIFO.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  N_REQ  per-requester data-valid.
REQ-008 req_data  input  N_REQ*DAT_BIT  flat requester data; requester i occupies bits [i*DAT_BIT +: DAT_BIT].
REQ-009 req_ready  output  N_REQ  per-requester accept; a beat transfers when req_valid[i] && req_ready[i].
REQ-010 fifo_wr_full  input  1  full flag from the FIFO write side.
REQ-011 fifo_wr_req  output  1  write strobe to the FIFO.
REQ-012 fifo_wr_data  output  DAT_BIT  write data to the FIFO.
REQ-013 grant_id  output  $clog2(N_REQ)  current owner index; valid only while busy=1.
REQ-014 busy  output  1  high while in GRANT.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-016 In IDLE with any req_valid high, the block SHALL choose the first valid requester scanning upward from last_owner+1 (mod N_REQ), load owner, clear beat_cnt, and enter GRANT on the next edge; this gives one cycle of arbitration latency.
REQ-017 In IDLE with no req_valid, the FSM SHALL stay in IDLE.
REQ-018 req_ready[i] SHALL be 1 only when state=GRANT, owner=i and fifo_wr_full=0; all other bits SHALL be 0.
REQ-019 fifo_wr_req SHALL equal req_valid[owner] && req_ready[owner] combinationally, with zero-cycle latency.
REQ-020 fifo_wr_data SHALL equal the owner's req_data slice in GRANT and 0 in IDLE.
REQ-021 Each transfer SHALL increment beat_cnt, which is $clog2(BURST_LEN+1) bits wide.
REQ-022 GRANT SHALL end, setting last_owner=owner and returning to IDLE, when the transfer making beat_cnt reach BURST_LEN occurs.
REQ-023 GRANT SHALL also end when req_valid[owner]=0 and fifo_wr_full=0 (owner idles).
REQ-024 While fifo_wr_full=1, the grant SHALL be held, beat_cnt frozen and no transfer issued, even if the owner drops valid.
REQ-025 A requester that is not the owner SHALL never transfer, whatever its req_valid.
REQ-026 When fifo_wr_full rises in the same cycle as the final beat, no transfer SHALL occur; the grant SHALL remain until that beat completes.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously set: state=IDLE, owner=0, last_owner=N_REQ-1 (requester 0 wins first), beat_cnt=0, and outputs req_ready=0, fifo_wr_req=0, fifo_wr_data=0, grant_id=0, busy=0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst; no partial-burst state SHALL survive.

Configuration
REQ-029 With macro ASYNC_FIFO_WR_ARB_STAT_EN defined, the block SHALL add input stat_clr (1 bit) and output stall_cnt (N_REQ*16).
REQ-030 With the macro, per-requester 16-bit counters SHALL increment each cycle that req_valid[i]=1 and req_ready[i]=0, saturate at 16'hFFFF, reset to 0, and clear synchronously on stat_clr; stat_clr wins over an increment in the same cycle.
REQ-031 Without the macro, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The state enum (IDLE, GRANT) and the stall counter width constant (16) SHALL live in a shared package, async_fifo_pkg.
REQ-033 The round-robin selection SHALL be a combinational sub-module, async_fifo_rr_pick, with inputs req vector and last_owner and outputs any_req and pick index.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- After reset, all req_valid=1, no full -> owner 0 gets 4 beats, then owners 1, 2, 3, 0 in turn, with one IDLE cycle between grants.
- Requester 2 alone sends 2 beats, then drops valid -> grant released after beat 2; grant_id=2 during it; last_owner=2.
- fifo_wr_full=1 for 3 cycles during beat 2 of requester 1 -> req_ready=0, fifo_wr_req=0, beat_cnt held; exactly 4 beats delivered in order.
- rst_n pulsed low during beat 3 -> all outputs 0 immediately; the next grant goes to requester 0.
- With ASYNC_FIFO_WR_ARB_STAT_EN, requester 3 waits 5 cycles -> stall_cnt[3]=5; stat_clr -> 0; a stall held for 70000 cycles -> counter stays at 16'hFFFF.
- BURST_LEN=1, req_valid=4'b0101 -> grants alternate 0, 2, 0, 2, one beat each.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The stall-statistics feature is enabled by defining ASYNC_FIFO_WR_ARB_STAT_EN.
package async_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Round-robin pick: first requester with i_req set, scanning upward from
// i_last_owner+1 and wrapping modulo N_REQ.
module async_fifo_rr_pick
    import async_fifo_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_last_owner,
    output logic             o_any_req,
    output logic [IW-1:0]    o_pick
);

    logic [IW-1:0] w_idx;

    // walk the ring once, starting just after the previous owner
    always_comb begin
        o_any_req = 1'b0;
        o_pick    = '0;
        w_idx     = i_last_owner;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
            if (!o_any_req && i_req[w_idx]) begin
                o_any_req = 1'b1;
                o_pick    = w_idx;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Burst arbiter that shares one FIFO write port between N_REQ requesters.
// Optional per-requester stall counters are built when ASYNC_FIFO_WR_ARB_STAT_EN
// is defined (adds ports stat_clr and stall_cnt).
//
// state | meaning
// IDLE  | no owner; round-robin pick happens here, one cycle of latency
// GRANT | owner may transfer up to BURST_LEN beats; held while FIFO is full
module async_fifo_wr_arb
    import async_fifo_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DAT_BIT   = 32,
    parameter  int BURST_LEN = 4,
    localparam int IW        = $clog2(N_REQ),
    localparam int BW        = $clog2(BURST_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DAT_BIT-1:0]   req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_wr_full,
`ifdef ASYNC_FIFO_WR_ARB_STAT_EN
    input  logic                       stat_clr,
    output logic [N_REQ*STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic                       fifo_wr_req,
    output logic [DAT_BIT-1:0]         fifo_wr_data,
    output logic [IW-1:0]              grant_id,
    output logic                       busy
);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nxt;
    logic [IW-1:0] r_last_owner;
    logic [IW-1:0] w_last_owner_nxt;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_cnt_nxt;

    logic               w_any_req;
    logic [IW-1:0]      w_pick;
    logic [DAT_BIT-1:0] w_owner_data;

    async_fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_last_owner (r_last_owner),
        .o_any_req    (w_any_req),
        .o_pick       (w_pick)
    );

    // owner's data slice, selected with constant indices only
    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_owner_data = req_data[i*DAT_BIT +: DAT_BIT];
            end
        end
    end

    // FSM state and burst bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= IW'(N_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    // next-state logic and all handshake outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        req_ready        = '0;
        fifo_wr_req      = 1'b0;
        fifo_wr_data     = '0;
        grant_id         = '0;
        busy             = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = GRANT;
                end
            end
            GRANT: begin
                busy         = 1'b1;
                grant_id     = r_owner;
                fifo_wr_data = w_owner_data;
                // a full FIFO freezes everything, including an owner that went idle
                if (!fifo_wr_full) begin
                    req_ready[r_owner] = 1'b1;
                    if (req_valid[r_owner]) begin
                        fifo_wr_req    = 1'b1;
                        w_beat_cnt_nxt = r_beat_cnt + BW'(1);
                        if (w_beat_cnt_nxt == BW'(BURST_LEN)) begin
                            w_last_owner_nxt = r_owner;
                            w_state_nxt      = IDLE;
                        end
                    end else begin
                        w_last_owner_nxt = r_owner;
                        w_state_nxt      = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef ASYNC_FIFO_WR_ARB_STAT_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stall
        logic [STALL_CNT_W-1:0] r_stall;

        // saturating count of cycles requester gi is held off; clear has priority
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stall <= '0;
            end else if (stat_clr) begin
                r_stall <= '0;
            end else if (req_valid[gi] && !req_ready[gi] && (r_stall != '1)) begin
                r_stall <= r_stall + STALL_CNT_W'(1);
            end
        end

        assign stall_cnt[gi*STALL_CNT_W +: STALL_CNT_W] = r_stall;
    end
`endif

endmodule
